// File: rtl/note_playback_scheduler_if.sv
// Note-path bus between the player/keypad control side and the playback scheduler.
interface note_playback_scheduler_if;
   logic       play_edge;
   logic       stop_edge;
   logic [1:0] tempo_sel;
   logic       key_valid;
   logic [3:0] key_note;
   logic [3:0] seq_note;
   logic       seq_done;
   logic       beat_tick;
   logic       seq_restart;
   logic [3:0] note_out;
   logic [1:0] active_src;
   logic       playing;

   modport master (
      output play_edge, stop_edge, tempo_sel, key_valid, key_note, seq_note, seq_done,
      input  beat_tick, seq_restart, note_out, active_src, playing
   );

   modport slave (
      input  play_edge, stop_edge, tempo_sel, key_valid, key_note, seq_note, seq_done,
      output beat_tick, seq_restart, note_out, active_src, playing
   );
endinterface

// File: rtl/note_playback_scheduler.sv
// Tempo strobe, play/pause/stop control and live-over-player note arbitration.
// Define NOTE_SCHED_AUTO_REPEAT_EN to loop the song on seq_done instead of stopping.
//
// state  | meaning
// IDLE   | stopped, note bus silent
// PLAY   | player drives the note bus, tempo counter running
// PAUSE  | player frozen, note bus silent
// LIVE   | keypad owns the bus (or release gap); ret_q holds where to go back
module note_playback_scheduler #(
   parameter int unsigned        TEMPO_W     = 16,
   parameter logic [TEMPO_W-1:0] TEMPO_BASE  = 16'd50000,
   parameter logic [7:0]         RELEASE_CYC = 8'd32
) (
   input logic clk,
   input logic rst,
   note_playback_scheduler_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_LIVE} state_t;

   state_t             state_q, state_d;
   state_t             ret_q, ret_d;
   logic [TEMPO_W-1:0] tempo_q, tempo_d;
   logic [7:0]         rel_q, rel_d;

   state_t             base_next;
   logic               restart;
   logic               load;
   logic               tick;
   logic [TEMPO_W-1:0] period_m1;

   assign period_m1 = (TEMPO_BASE >> bus.tempo_sel) - TEMPO_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ret_q   <= S_IDLE;
         tempo_q <= '0;
         rel_q   <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         tempo_q <= tempo_d;
         rel_q   <= rel_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      tempo_d   = tempo_q;
      rel_d     = rel_q;
      base_next = state_q;
      restart   = 1'b0;
      load      = 1'b0;
      // The key entry cycle freezes the tempo counter, so it never ticks.
      tick      = (state_q == S_PLAY) && !bus.key_valid && (tempo_q == '0);

      case (state_q)
         S_IDLE: begin
            if (bus.play_edge) begin
               base_next = S_PLAY;
               restart   = 1'b1;
               load      = 1'b1;
            end
         end
         S_PLAY: begin
            if (bus.stop_edge) begin
               base_next = S_IDLE;
               restart   = 1'b1;
            end else if (bus.seq_done) begin
`ifdef NOTE_SCHED_AUTO_REPEAT_EN
               restart   = 1'b1;
               load      = 1'b1;
`else
               base_next = S_IDLE;
               restart   = 1'b1;
`endif
            end else if (bus.play_edge) begin
               base_next = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (bus.stop_edge) begin
               base_next = S_IDLE;
               restart   = 1'b1;
            end else if (bus.play_edge) begin
               base_next = S_PLAY;
            end
         end
         default: begin
            if (bus.stop_edge) begin
               ret_d   = S_IDLE;
               restart = 1'b1;
            end else if (bus.play_edge) begin
               case (ret_q)
                  S_IDLE: begin
                     ret_d   = S_PLAY;
                     restart = 1'b1;
                     load    = 1'b1;
                  end
                  S_PLAY:  ret_d = S_PAUSE;
                  default: ret_d = S_PLAY;
               endcase
            end
            if (bus.key_valid) begin
               rel_d = RELEASE_CYC;
            end else if (rel_q <= 8'd1) begin
               state_d = ret_d;
               rel_d   = '0;
            end else begin
               rel_d = rel_q - 8'd1;
            end
         end
      endcase

      if (state_q != S_LIVE) begin
         if (bus.key_valid) begin
            state_d = S_LIVE;
            ret_d   = base_next;
            rel_d   = RELEASE_CYC;
         end else begin
            state_d = base_next;
         end
      end

      if (load || tick) begin
         tempo_d = period_m1;
      end else if ((state_q == S_PLAY) && !bus.key_valid) begin
         tempo_d = tempo_q - TEMPO_W'(1);
      end
   end

   always_comb begin
      bus.note_out   = 4'hF;
      bus.active_src = 2'b00;
      bus.playing    = 1'b0;
      case (state_q)
         S_PLAY: begin
            bus.note_out   = bus.seq_note;
            bus.active_src = 2'b01;
            bus.playing    = 1'b1;
         end
         S_LIVE: begin
            if (bus.key_valid) begin
               bus.note_out   = bus.key_note;
               bus.active_src = 2'b10;
            end
            bus.playing = (ret_q == S_PLAY);
         end
         default: ;
      endcase
   end

   assign bus.beat_tick   = tick;
   assign bus.seq_restart = restart && !rst;

endmodule

// File: tb/tb_note_playback_scheduler.sv
// Randomized bench for note_playback_scheduler: reference model feeds a scoreboard, a negedge monitor compares.
module tb_note_playback_scheduler;

   localparam int TB_BASE = 8;
   localparam int TB_REL  = 3;

   localparam int M_IDLE  = 0;
   localparam int M_PLAY  = 1;
   localparam int M_PAUSE = 2;
   localparam int M_LIVE  = 3;

   typedef struct packed {
      logic       tick;
      logic       restart;
      logic [3:0] note;
      logic [1:0] src;
      logic       play;
   } exp_t;

   logic clk;
   logic rst;
   note_playback_scheduler_if bus();

   note_playback_scheduler #(
      .TEMPO_W    (16),
      .TEMPO_BASE (16'(TB_BASE)),
      .RELEASE_CYC(8'(TB_REL))
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode, return mode, elapsed cycles in the current beat, and release-gap length.
   int m_st = M_IDLE, m_ret = M_IDLE, m_phase = 0, m_per = 1, m_gap = 0;

   bit       kv_r  = 1'b0;
   bit [3:0] kn_r  = 4'h0;
   bit [1:0] ts_r  = 2'd0;
   bit       rst_r = 1'b1;

   task automatic model_step();
      exp_t e;
      int   nxt, period;
      bit   rs, ld;
      e = '{tick: 1'b0, restart: 1'b0, note: 4'hF, src: 2'b00, play: 1'b0};
      if (rst) begin
         m_st = M_IDLE; m_ret = M_IDLE; m_phase = 0; m_per = 1; m_gap = 0;
         sb.push_back(e);
         return;
      end
      period = TB_BASE >> bus.tempo_sel;
      rs = 1'b0; ld = 1'b0; nxt = m_st;
      if (m_st == M_PLAY) begin
         e.note = bus.seq_note; e.src = 2'b01; e.play = 1'b1;
      end else if (m_st == M_LIVE) begin
         if (bus.key_valid) begin
            e.note = bus.key_note; e.src = 2'b10;
         end
         e.play = (m_ret == M_PLAY);
      end

      if (m_st == M_LIVE) begin
         if (bus.stop_edge) begin
            m_ret = M_IDLE; rs = 1'b1;
         end else if (bus.play_edge) begin
            if (m_ret == M_IDLE) begin m_ret = M_PLAY; rs = 1'b1; ld = 1'b1; end
            else if (m_ret == M_PLAY) m_ret = M_PAUSE;
            else m_ret = M_PLAY;
         end
         if (ld) begin m_phase = 0; m_per = period; end
         if (bus.key_valid) m_gap = 0;
         else if (m_gap + 1 >= TB_REL) begin m_st = m_ret; m_gap = 0; end
         else m_gap++;
      end else begin
         if (m_st == M_IDLE) begin
            if (bus.play_edge) begin nxt = M_PLAY; rs = 1'b1; ld = 1'b1; end
         end else if (m_st == M_PLAY) begin
            if (bus.stop_edge) begin nxt = M_IDLE; rs = 1'b1; end
            else if (bus.seq_done) begin
`ifdef NOTE_SCHED_AUTO_REPEAT_EN
               rs = 1'b1; ld = 1'b1;
`else
               nxt = M_IDLE; rs = 1'b1;
`endif
            end else if (bus.play_edge) nxt = M_PAUSE;
         end else begin
            if (bus.stop_edge) begin nxt = M_IDLE; rs = 1'b1; end
            else if (bus.play_edge) nxt = M_PLAY;
         end
         if (m_st == M_PLAY && !bus.key_valid) begin
            if (m_phase == m_per - 1) begin
               e.tick = 1'b1; m_phase = 0; m_per = period;
            end else begin
               m_phase++;
            end
         end
         if (ld) begin m_phase = 0; m_per = period; end
         if (bus.key_valid) begin m_ret = nxt; m_st = M_LIVE; m_gap = 0; end
         else m_st = nxt;
      end
      e.restart = rs;
      sb.push_back(e);
   endtask

   task automatic step(input bit pe, input bit se, input bit sd);
      @(posedge clk);
      #1;
      rst           = rst_r;
      bus.play_edge = pe;
      bus.stop_edge = se;
      bus.seq_done  = sd;
      bus.key_valid = kv_r;
      bus.key_note  = kn_r;
      bus.tempo_sel = ts_r;
      bus.seq_note  = 4'($urandom_range(0, 15));
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp("beat_tick",   int'(bus.beat_tick),   int'(e.tick));
         cmp("seq_restart", int'(bus.seq_restart), int'(e.restart));
         cmp("note_out",    int'(bus.note_out),    int'(e.note));
         cmp("active_src",  int'(bus.active_src),  int'(e.src));
         cmp("playing",     int'(bus.playing),     int'(e.play));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst           = 1'b1;
      bus.play_edge = 1'b0;
      bus.stop_edge = 1'b0;
      bus.seq_done  = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_note  = 4'h0;
      bus.seq_note  = 4'h0;
      bus.tempo_sel = 2'd0;

      rst_r = 1'b1;
      idle(3);
      rst_r = 1'b0;
      idle(9);
      step(1'b1, 1'b0, 1'b0);
      idle(27);
      ts_r = 2'd2;
      idle(12);
      step(1'b1, 1'b0, 1'b0);
      idle(6);
      step(1'b1, 1'b0, 1'b0);
      idle(6);
      ts_r = 2'd0;
      idle(3);
      kv_r = 1'b1; kn_r = 4'h4;
      idle(5);
      kv_r = 1'b0;
      idle(12);
      step(1'b1, 1'b1, 1'b0);
      idle(4);
      step(1'b1, 1'b0, 1'b0);
      idle(5);
      step(1'b0, 1'b0, 1'b1);
      idle(12);
      step(1'b1, 1'b0, 1'b0);
      idle(3);
      kv_r = 1'b1; kn_r = 4'h9;
      idle(3);
      kv_r = 1'b0;
      idle(1);
      kv_r = 1'b1;
      idle(2);
      rst_r = 1'b1;
      idle(2);
      rst_r = 1'b0;
      idle(3);
      step(1'b1, 1'b0, 1'b0);
      kv_r = 1'b0;
      idle(8);
      step(1'b1, 1'b0, 1'b0);
      kv_r = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      kv_r = 1'b0;
      idle(10);

      for (int c = 0; c < 4000; c++) begin
         bit pe, se, sd;
         pe = ($urandom_range(0, 14) == 0);
         se = ($urandom_range(0, 59) == 0);
         sd = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 29) == 0) begin
            kv_r = ~kv_r;
            if (kv_r) kn_r = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 99) == 0) ts_r = 2'($urandom_range(0, 3));
         rst_r = ($urandom_range(0, 599) == 0);
         step(pe, se, sd);
      end
      rst_r = 1'b0;
      kv_r  = 1'b0;
      idle(3);

      @(posedge clk);
      @(negedge clk);
      #1;
      cmp("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
